// File: rtl/sr_cmd_conditioner_if.sv
// Command bus between the push-button conditioner and its environment.
// The master side is the conditioner: it receives the raw button levels and
// drives the sr command, the conflict pulse and the busy flag.
// The slave side is the surrounding logic (buttons in, flip-flop command out).
interface sr_cmd_conditioner_if;
   logic       set_in;
   logic       clr_in;
   logic [1:0] sr;
   logic       conflict;
   logic       busy;

   modport master (
      input  set_in,
      input  clr_in,
      output sr,
      output conflict,
      output busy
   );

   modport slave (
      output set_in,
      output clr_in,
      input  sr,
      input  conflict,
      input  busy
   );
endinterface

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: front end for the srff flip-flop.
// Two raw push-button levels (set, clear) are synchronised, debounced and
// converted into one clean sr[1:0] command pulse per press
// (10 = set, 01 = clear, 00 = hold). The code 11 is never driven.
//
// Build option: define SR_CLEAR_PRIORITY_EN to make clear win when both
// buttons are accepted in the same cycle. Without it, a simultaneous press
// issues no command; the FSM only waits for both buttons to be released.
// In both builds such a cycle raises conflict for one cycle.
module sr_cmd_conditioner #(
   parameter int unsigned DB_CYCLES    = 4,
   parameter int unsigned PULSE_CYCLES = 1,
   parameter int unsigned CNT_W        = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   sr_cmd_conditioner_if.master bus
);

   // Counter terminal values: the counters start at zero, so the last count
   // before acting is N-1.
   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_REL = 2'd2
   } state_t;

   // Bit 1 is the set channel, bit 0 the clear channel.
   logic [1:0] raw;
   logic [1:0] db_lvl;

   assign raw = {bus.set_in, bus.clr_in};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         logic             s1;
         logic             s2;
         logic             db;
         logic [CNT_W-1:0] cnt;

         // Two-flop synchroniser for the asynchronous button level.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1 <= 1'b0;
               s2 <= 1'b0;
            end else begin
               s1 <= raw[gi];
               s2 <= s1;
            end
         end

         // Debounce: accept a new level only after it has differed from the
         // accepted level for DB_CYCLES consecutive cycles; any return to the
         // accepted level restarts the count, so short bounces are dropped.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               db  <= 1'b0;
               cnt <= '0;
            end else if (s2 == db) begin
               cnt <= '0;
            end else if (cnt == DB_LAST) begin
               db  <= s2;
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end

         assign db_lvl[gi] = db;
      end
   endgenerate

   logic set_db;
   logic clr_db;

   assign set_db = db_lvl[1];
   assign clr_db = db_lvl[0];

   state_t           state;
   logic [1:0]       cmd_code;
   logic             conflict_pulse;
   logic             busy_flag;
   logic [CNT_W-1:0] pulse_cnt;

   // Command FSM with registered outputs: one pulse per press, then wait for
   // both buttons to be released before another command can be issued.
   // busy_flag is updated together with every state change so it always
   // equals (state != IDLE).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cmd_code       <= 2'b00;
         conflict_pulse <= 1'b0;
         busy_flag      <= 1'b0;
         pulse_cnt      <= '0;
      end else begin
         conflict_pulse <= 1'b0;
         case (state)
            IDLE: begin
               pulse_cnt <= '0;
               if (set_db && clr_db) begin
                  conflict_pulse <= 1'b1;
                  busy_flag      <= 1'b1;
`ifdef SR_CLEAR_PRIORITY_EN
                  state          <= ISSUE;
                  cmd_code       <= 2'b01;
`else
                  state          <= WAIT_REL;
                  cmd_code       <= 2'b00;
`endif
               end else if (set_db) begin
                  state     <= ISSUE;
                  cmd_code  <= 2'b10;
                  busy_flag <= 1'b1;
               end else if (clr_db) begin
                  state     <= ISSUE;
                  cmd_code  <= 2'b01;
                  busy_flag <= 1'b1;
               end else begin
                  cmd_code  <= 2'b00;
                  busy_flag <= 1'b0;
               end
            end

            ISSUE: begin
               // Buttons accepted here are ignored; only the pulse timer runs.
               if (pulse_cnt == PULSE_LAST) begin
                  state     <= WAIT_REL;
                  cmd_code  <= 2'b00;
                  pulse_cnt <= '0;
               end else begin
                  pulse_cnt <= pulse_cnt + CNT_W'(1);
               end
            end

            WAIT_REL: begin
               cmd_code <= 2'b00;
               if (!set_db && !clr_db) begin
                  state     <= IDLE;
                  busy_flag <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               cmd_code  <= 2'b00;
               busy_flag <= 1'b0;
               pulse_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.sr       = cmd_code;
   assign bus.conflict = conflict_pulse;
   assign bus.busy     = busy_flag;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Testbench for sr_cmd_conditioner.
// A reference model driven from the raw button history predicts, per clock
// edge, the command events and the sr/busy/conflict outputs; a separate
// monitor compares the DUT against those queues on every falling edge.
module tb_sr_cmd_conditioner;

   localparam int DB   = 4;
   localparam int P    = 3;
   localparam int CW   = 8;
   localparam int NMAX = 32768;

`ifdef SR_CLEAR_PRIORITY_EN
   localparam bit CLR_PRI = 1'b1;
`else
   localparam bit CLR_PRI = 1'b0;
`endif

   typedef struct {
      int         e;
      logic [1:0] code;
      logic       conf;
   } ev_t;

   typedef struct {
      int         e;
      logic [1:0] sr;
      logic       busy;
      logic       conf;
   } cyc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sr_cmd_conditioner_if bus_if();

   sr_cmd_conditioner #(
      .DB_CYCLES   (DB),
      .PULSE_CYCLES(P),
      .CNT_W       (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   int n_tests  = 0;
   int n_fail   = 0;
   int edge_cnt = 0;
   int mon_from = 1 << 30;

   ev_t  ev_q[$];
   cyc_t cyc_q[$];

   // Reference model state: button history and the accepted levels.
   bit         xs[2][NMAX];
   int         base;
   int         flip_at[2];
   bit         mdb[2];
   bit         m_idle;
   int         code_start;
   int         code_end;
   int         rel_from;
   logic [1:0] m_code;
   logic [1:0] m_last_sr;

   initial forever begin
      @(posedge clk);
      edge_cnt++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_cnt);
      end
   endtask

   function automatic bit getx(input int ch, input int j);
      if (j < base || j < 0) return 1'b0;
      return xs[ch][j];
   endfunction

   task automatic model_reset(input int e0);
      base       = e0;
      flip_at[0] = e0 - 1;
      flip_at[1] = e0 - 1;
      mdb[0]     = 1'b0;
      mdb[1]     = 1'b0;
      m_idle     = 1'b1;
      code_start = 0;
      code_end   = 0;
      rel_from   = 0;
      m_code     = 2'b00;
      m_last_sr  = 2'b00;
   endtask

   // Predict everything that happens at clock edge e; s/c are the raw levels
   // sampled at that edge.
   task automatic model_edge(input int e, input bit s, input bit c);
      bit         conf;
      bit         all_diff;
      logic [1:0] exp_sr;
      conf = 1'b0;
      xs[1][e] = s;
      xs[0][e] = c;
      // Command decision uses the levels accepted before this edge.
      if (m_idle) begin
         if (mdb[1] || mdb[0]) begin
            m_idle = 1'b0;
            conf   = mdb[1] && mdb[0];
            if (conf && !CLR_PRI) begin
               m_code     = 2'b00;
               code_start = e;
               code_end   = e;
               rel_from   = e + 1;
            end else begin
               m_code     = mdb[0] ? 2'b01 : 2'b10;
               code_start = e;
               code_end   = e + P;
               rel_from   = e + P + 1;
            end
            ev_q.push_back('{e, m_code, conf});
         end
      end else if (e >= rel_from && !mdb[1] && !mdb[0]) begin
         m_idle = 1'b1;
      end
      exp_sr    = (e >= code_start && e < code_end) ? m_code : 2'b00;
      m_last_sr = exp_sr;
      cyc_q.push_back('{e, exp_sr, !m_idle, conf});
      // A level is accepted once the synchronised input (raw delayed by two
      // edges) has differed from the accepted level for DB whole cycles.
      for (int ch = 0; ch < 2; ch++) begin
         if (e - DB >= flip_at[ch]) begin
            all_diff = 1'b1;
            for (int j = e - DB - 1; j <= e - 2; j++)
               if (getx(ch, j) == mdb[ch]) all_diff = 1'b0;
            if (all_diff) begin
               mdb[ch]     = !mdb[ch];
               flip_at[ch] = e;
            end
         end
      end
   endtask

   task automatic step(input bit s, input bit c);
      @(negedge clk);
      bus_if.set_in = s;
      bus_if.clr_in = c;
      if (!rst) model_edge(edge_cnt + 1, s, c);
   endtask

   task automatic do_release();
      @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset(edge_cnt + 1);
      mon_from = edge_cnt + 1;
   endtask

   // Monitor: compare DUT outputs against the predicted queues.
   initial begin
      cyc_t       cx;
      ev_t        ex;
      int         run_len;
      logic [1:0] prev_sr;
      run_len = 0;
      prev_sr = 2'b00;
      forever begin
         @(negedge clk);
         if (edge_cnt >= mon_from) begin
            check("sr_not_11", (bus_if.sr == 2'b11) ? 1 : 0, 0);
            check("cyc_q_nonempty", (cyc_q.size() > 0) ? 1 : 0, 1);
            if (cyc_q.size() > 0) begin
               cx = cyc_q.pop_front();
               check("cyc_stamp", cx.e, edge_cnt);
               check("sr", int'(bus_if.sr), int'(cx.sr));
               check("busy", int'(bus_if.busy), int'(cx.busy));
               check("conflict", int'(bus_if.conflict), int'(cx.conf));
            end
            if ((bus_if.sr != 2'b00 && prev_sr == 2'b00) || bus_if.conflict) begin
               $display("[TB] edge %0d command sr=%b conflict=%b busy=%b",
                        edge_cnt, bus_if.sr, bus_if.conflict, bus_if.busy);
               check("ev_q_nonempty", (ev_q.size() > 0) ? 1 : 0, 1);
               if (ev_q.size() > 0) begin
                  ex = ev_q.pop_front();
                  check("ev_edge", edge_cnt, ex.e);
                  check("ev_code", int'(bus_if.sr), int'(ex.code));
                  check("ev_conflict", int'(bus_if.conflict), int'(ex.conf));
               end
            end
            if (bus_if.sr != 2'b00) begin
               run_len++;
            end else if (run_len > 0) begin
               check("pulse_len", run_len, P);
               run_len = 0;
            end
            prev_sr = bus_if.sr;
         end else begin
            run_len = 0;
            prev_sr = 2'b00;
         end
      end
   end

   // Stimulus.
   initial begin
      bit lv[2];
      bus_if.set_in = 1'b0;
      bus_if.clr_in = 1'b0;
      rst = 1'b1;
      model_reset(0);

      repeat (3) @(posedge clk);
      #1;
      check("reset_sr", int'(bus_if.sr), 0);
      check("reset_busy", int'(bus_if.busy), 0);
      check("reset_conflict", int'(bus_if.conflict), 0);
      do_release();

      // Clean set press, held, then released.
      repeat (20) step(1'b1, 1'b0);
      repeat (15) step(1'b0, 1'b0);

      // Clear button bouncing every 2 cycles: nothing may be accepted.
      for (int i = 0; i < 20; i++) step(1'b0, ((i / 2) % 2) == 1);
      repeat (10) step(1'b0, 1'b0);

      // Both buttons rise together.
      repeat (15) step(1'b1, 1'b1);
      repeat (15) step(1'b0, 1'b0);

      // Set held, clear pressed during the release wait, then both released.
      repeat (15) step(1'b1, 1'b0);
      repeat (10) step(1'b1, 1'b1);
      repeat (15) step(1'b0, 1'b0);

      // Reset in the middle of a pulse.
      for (int i = 0; i < 40 && m_last_sr == 2'b00; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("pre_reset_sr", int'(bus_if.sr), 2);
      #1;
      mon_from = 1 << 30;
      rst = 1'b1;
      bus_if.set_in = 1'b0;
      #1;
      check("mid_reset_sr", int'(bus_if.sr), 0);
      check("mid_reset_busy", int'(bus_if.busy), 0);
      check("mid_reset_conflict", int'(bus_if.conflict), 0);
      cyc_q.delete();
      ev_q.delete();
      repeat (3) @(negedge clk);
      do_release();
      repeat (20) step(1'b0, 1'b0);
      repeat (15) step(1'b0, 1'b1);
      repeat (15) step(1'b0, 1'b0);

      // Random bouncing buttons.
      lv[0] = 1'b0;
      lv[1] = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         for (int ch = 0; ch < 2; ch++)
            if ($urandom_range(0, 9) == 0) lv[ch] = !lv[ch];
         step(lv[1], lv[0]);
      end
      repeat (30) step(1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("ev_q_drained", ev_q.size(), 0);
      check("cyc_q_drained", cyc_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
